// File: rtl/conv_window_sched_pkg.sv
// conv_window_sched_pkg: types and constants shared by the 3x3 convolution
// window sequencer, its line buffer and the conv_core datapath.
//   PIX_BITS  - width of a Q1.6 pixel or coefficient
//   FRAC_BITS - fractional bits removed from each product
//   BITS_Q4_6 - width of a convolution result (Q4.6 plus sign)
`timescale 1ns/1ps
package conv_window_sched_pkg;
   localparam int PIX_BITS  = 8;
   localparam int FRAC_BITS = 6;
   localparam int BITS_Q4_6 = 11;

   typedef logic signed [PIX_BITS-1:0] pix_t;
   typedef pix_t  [2:0] vec3_t;      // one row, index 0 = leftmost
   typedef vec3_t [2:0] matrix_3x3;  // [row][col], row 0 = top

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_KLOAD  = 3'd1,
      S_STREAM = 3'd2,
      S_DRAIN  = 3'd3,
      S_DONE   = 3'd4
   } sched_state_t;
endpackage

// File: rtl/conv_core.sv
// conv_core: combinational 3x3 multiply-accumulate. Each of the nine products
// is arithmetically shifted right by FRAC_BITS before summing; the sum is
// truncated to BITS_Q4_6 bits (no saturation).
//   kern_i - 3x3 Q1.6 kernel
//   win_i  - 3x3 Q1.6 pixel window
//   res_o  - Q4.6 signed result
`timescale 1ns/1ps
import conv_window_sched_pkg::*;

module conv_core (
   input  matrix_3x3              kern_i,
   input  matrix_3x3              win_i,
   output logic [BITS_Q4_6-1:0]   res_o
);
   localparam int PW = 2 * PIX_BITS;

   // Summing modulo 2^11 gives the same bits as a wide sum then truncation.
   always_comb begin
      res_o = '0;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            res_o = res_o + BITS_Q4_6'((PW'($signed(kern_i[r][c])) *
                                        PW'($signed(win_i[r][c]))) >>> FRAC_BITS);
         end
      end
   end
endmodule

// File: rtl/conv_window_sched_line_buffer.sv
// conv_line_buffer: two image-row delay lines for building 3x3 windows.
// lb0 holds the previous row, lb1 the row before that, both indexed by column.
//   clk, rst_n - clock, async active-low reset
//   we_i       - pixel accepted this cycle
//   col_i      - column of the accepted pixel
//   pix_i      - accepted pixel
//   lb1_o/lb0_o- stored pixels at col_i (two rows up / one row up)
`timescale 1ns/1ps
import conv_window_sched_pkg::*;

module conv_line_buffer #(
   parameter int IMG_W = 8,
   parameter int CW    = $clog2(IMG_W)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we_i,
   input  logic [CW-1:0] col_i,
   input  pix_t          pix_i,
   output pix_t          lb1_o,
   output pix_t          lb0_o
);
   pix_t [IMG_W-1:0] lb0_q, lb0_d, lb1_q, lb1_d;

   assign lb0_o = lb0_q[col_i];
   assign lb1_o = lb1_q[col_i];

   always_comb begin
      lb0_d = lb0_q;
      lb1_d = lb1_q;
      if (we_i) begin
         lb1_d[col_i] = lb0_q[col_i];
         lb0_d[col_i] = pix_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lb0_q <= '0;
         lb1_q <= '0;
      end else begin
         lb0_q <= lb0_d;
         lb1_q <= lb1_d;
      end
   end
endmodule

// File: rtl/conv_window_sched.sv
// conv_window_sched: loads a 3x3 Q1.6 kernel serially, then turns a raster
// pixel stream into sliding 3x3 windows and emits one conv_core result per
// full window on a registered valid/ready port.
//   start_i/busy_o/done_o        - frame control and status
//   k_valid_i/k_data_i/k_ready_o - kernel load, row-major k00..k22
//   pix_valid_i/pix_data_i/pix_ready_o - pixel stream
//   out_valid_o/out_data_o/out_last_o/out_ready_i - result stream
// Optional build macro CONV_RELU_EN: clamp negative results to 0.
`timescale 1ns/1ps
import conv_window_sched_pkg::*;

module conv_window_sched #(
   parameter int IMG_W = 8,
   parameter int IMG_H = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start_i,
   input  logic                 k_valid_i,
   input  logic [7:0]           k_data_i,
   output logic                 k_ready_o,
   input  logic                 pix_valid_i,
   input  logic [7:0]           pix_data_i,
   output logic                 pix_ready_o,
   output logic                 out_valid_o,
   output logic [10:0]          out_data_o,
   output logic                 out_last_o,
   input  logic                 out_ready_i,
   output logic                 busy_o,
   output logic                 done_o
);
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

   sched_state_t              state_q, state_d;
   logic [3:0]                k_idx_q, k_idx_d;
   pix_t [8:0]                kflat_q, kflat_d;
   logic [RW-1:0]             row_q, row_d;
   logic [CW-1:0]             col_q, col_d;
   matrix_3x3                 win_q, win_d, kern_m;
   logic                      out_valid_q, out_valid_d;
   logic [BITS_Q4_6-1:0]      out_data_q, out_data_d;
   logic                      out_last_q, out_last_d;
   logic                      pix_acc, emit, last_pix;
   pix_t                      lb0_rd, lb1_rd;
   logic [BITS_Q4_6-1:0]      core_res;

   assign k_ready_o   = (state_q == S_KLOAD);
   assign pix_ready_o = (state_q == S_STREAM) && (!out_valid_q || out_ready_i);
   assign busy_o      = (state_q != S_IDLE);
   assign done_o      = (state_q == S_DONE);
   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;
   assign out_last_o  = out_last_q;

   assign pix_acc  = pix_valid_i && pix_ready_o;
   // col>=2 keeps windows from straddling a row wrap
   assign emit     = pix_acc && (row_q >= RW'(2)) && (col_q >= CW'(2));
   assign last_pix = (row_q == ROW_LAST) && (col_q == COL_LAST);

   always_comb begin
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            kern_m[r][c] = kflat_q[r*3 + c];
   end

   conv_line_buffer #(.IMG_W(IMG_W), .CW(CW)) u_lb (
      .clk   (clk),
      .rst_n (rst_n),
      .we_i  (pix_acc),
      .col_i (col_q),
      .pix_i (pix_t'(pix_data_i)),
      .lb1_o (lb1_rd),
      .lb0_o (lb0_rd)
   );

   // The core sees the post-shift window so the result registers on the
   // same edge that accepts the pixel.
   conv_core u_core (
      .kern_i (kern_m),
      .win_i  (win_d),
      .res_o  (core_res)
   );

   always_comb begin
      state_d     = state_q;
      k_idx_d     = k_idx_q;
      kflat_d     = kflat_q;
      row_d       = row_q;
      col_d       = col_q;
      win_d       = win_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;

      if (pix_acc) begin
         for (int r = 0; r < 3; r++) begin
            win_d[r][0] = win_q[r][1];
            win_d[r][1] = win_q[r][2];
         end
         win_d[0][2] = lb1_rd;
         win_d[1][2] = lb0_rd;
         win_d[2][2] = pix_t'(pix_data_i);
      end

      case (state_q)
         S_IDLE: if (start_i) begin
            state_d = S_KLOAD;
            k_idx_d = '0;
         end
         S_KLOAD: if (k_valid_i) begin
            kflat_d[k_idx_q] = pix_t'(k_data_i);
            k_idx_d          = k_idx_q + 4'd1;
            if (k_idx_q == 4'd8) begin
               state_d = S_STREAM;
               k_idx_d = '0;
               row_d   = '0;
               col_d   = '0;
            end
         end
         S_STREAM: if (pix_acc) begin
            if (col_q == COL_LAST) begin
               col_d = '0;
               row_d = row_q + 1'b1;
            end else begin
               col_d = col_q + 1'b1;
            end
            if (last_pix) begin
               state_d = S_DRAIN;
               row_d   = '0;
            end
         end
         S_DRAIN: if (out_valid_q && out_ready_i && out_last_q) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Handshake frees the register; a new result in the same cycle wins.
      if (out_valid_q && out_ready_i) out_valid_d = 1'b0;
      if (emit) begin
         out_valid_d = 1'b1;
         out_last_d  = last_pix;
`ifdef CONV_RELU_EN
         out_data_d  = core_res[BITS_Q4_6-1] ? '0 : core_res;
`else
         out_data_d  = core_res;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         k_idx_q     <= '0;
         kflat_q     <= '0;
         row_q       <= '0;
         col_q       <= '0;
         win_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         k_idx_q     <= k_idx_d;
         kflat_q     <= kflat_d;
         row_q       <= row_d;
         col_q       <= col_d;
         win_q       <= win_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
      end
   end
endmodule

// File: tb/tb_conv_window_sched.sv
// Bench for conv_window_sched on a 4x4 frame: a table of kernels and pixel
// patterns with hand-computed results, plus a mid-frame reset sequence.
`timescale 1ns/1ps
module tb_conv_window_sched;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_i, k_valid_i, pix_valid_i, out_ready_i;
   logic [7:0]  k_data_i, pix_data_i;
   logic        k_ready_o, pix_ready_o, out_valid_o, out_last_o, busy_o, done_o;
   logic [10:0] out_data_o;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   conv_window_sched #(.IMG_W(4), .IMG_H(4)) dut (
      .clk(clk), .rst_n(rst_n), .start_i(start_i),
      .k_valid_i(k_valid_i), .k_data_i(k_data_i), .k_ready_o(k_ready_o),
      .pix_valid_i(pix_valid_i), .pix_data_i(pix_data_i), .pix_ready_o(pix_ready_o),
      .out_valid_o(out_valid_o), .out_data_o(out_data_o), .out_last_o(out_last_o),
      .out_ready_i(out_ready_i), .busy_o(busy_o), .done_o(done_o)
   );

   typedef struct {
      logic [8:0][7:0]  k;     // k[0]=k00 .. k[8]=k22
      bit               ramp;  // pixels 1..16, else constant 64
      bit               gaps;  // gapped kernel load + start pulse mid-stream
      bit               bp;    // random output backpressure / pixel gaps
      logic [3:0][10:0] exp;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic run_frame(input vec_t v, input int id);
      int pi = 0, nres = 0, cyc = 0;
      bit stalled = 0;
      logic [11:0] held = '0;
      @(negedge clk) start_i = 1'b1;
      @(negedge clk) start_i = 1'b0;
      for (int i = 0; i < 9; i++) begin
         if (v.gaps) begin
            @(negedge clk) k_valid_i = 1'b0;
         end
         @(negedge clk);
         k_valid_i = 1'b1;
         k_data_i  = v.k[i];
         #1 chk($sformatf("v%0d k_ready", id), 32'(k_ready_o), 32'd1);
      end
      while (nres < 4 && cyc < 400) begin
         @(negedge clk);
         cyc++;
         k_valid_i   = 1'b0;
         out_ready_i = v.bp ? 1'($urandom_range(0, 1)) : 1'b1;
         pix_valid_i = (pi < 16) && (v.bp ? ($urandom_range(0, 3) != 0) : 1'b1);
         pix_data_i  = v.ramp ? 8'(pi + 1) : 8'd64;
         start_i     = v.gaps && (pi == 5);
         #1;
         if (stalled)
            chk($sformatf("v%0d stall hold", id), 32'({out_last_o, out_data_o}), 32'(held));
         if (out_valid_o && !out_ready_i)
            chk($sformatf("v%0d pix_ready in stall", id), 32'(pix_ready_o), 32'd0);
         if (pix_valid_i && pix_ready_o) pi++;
         if (out_valid_o && out_ready_i) begin
            chk($sformatf("v%0d result %0d", id, nres), 32'(out_data_o), 32'(v.exp[nres]));
            chk($sformatf("v%0d last %0d", id, nres), 32'(out_last_o), 32'(nres == 3));
            nres++;
         end
         stalled = out_valid_o && !out_ready_i;
         held    = {out_last_o, out_data_o};
      end
      start_i = 1'b0; pix_valid_i = 1'b0;
      if (cyc >= 400) begin
         n_chk++; n_fail++;
         $display("FAIL v%0d timeout: got %0d results, expected 4", id, nres);
      end
      chk($sformatf("v%0d pixels taken", id), 32'(pi), 32'd16);
      @(negedge clk) #1 chk($sformatf("v%0d done pulse", id), 32'(done_o), 32'd1);
      @(negedge clk) #1 chk($sformatf("v%0d done/busy clear", id), 32'({done_o, busy_o}), 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 7; i++) begin
         vecs[i].k = '0; vecs[i].ramp = 1'b1; vecs[i].gaps = 1'b0; vecs[i].bp = 1'b0;
      end
      // identity
      vecs[0].k[4] = 8'd64; vecs[0].exp = {11'd11, 11'd10, 11'd7, 11'd6};
      // all ones, constant 64 -> 9*64
      vecs[1].k = {9{8'd64}}; vecs[1].ramp = 1'b0; vecs[1].exp = {4{11'd576}};
      // center -1.0, constant 64 -> -64
      vecs[2].k[4] = 8'hC0; vecs[2].ramp = 1'b0;
`ifdef CONV_RELU_EN
      vecs[2].exp = '0;
`else
      vecs[2].exp = {4{11'h7C0}};
`endif
      // top-left tap: pixel two rows up, two cols left; gapped load
      vecs[3].k[0] = 8'd64; vecs[3].gaps = 1'b1; vecs[3].exp = {11'd6, 11'd5, 11'd2, 11'd1};
      // bottom-right tap: current pixel; backpressure
      vecs[4].k[8] = 8'd64; vecs[4].bp = 1'b1; vecs[4].exp = {11'd16, 11'd15, 11'd12, 11'd11};
      // k01=+0.5, k21=-0.5: per-product floor shift gives -4,-5,-4,-5
      vecs[5].k[1] = 8'h20; vecs[5].k[7] = 8'hE0; vecs[5].bp = 1'b1;
`ifdef CONV_RELU_EN
      vecs[5].exp = '0;
`else
      vecs[5].exp = {11'h7FB, 11'h7FC, 11'h7FB, 11'h7FC};
`endif
      // identity under backpressure
      vecs[6] = vecs[0]; vecs[6].bp = 1'b1;

      rst_n = 1'b0; start_i = 0; k_valid_i = 0; k_data_i = 0;
      pix_valid_i = 0; pix_data_i = 0; out_ready_i = 0;
      repeat (2) @(negedge clk);
      #1 chk("reset outputs", 32'({k_ready_o, pix_ready_o, out_valid_o, out_data_o,
                                    out_last_o, busy_o, done_o}), 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 7; i++) run_frame(vecs[i], i);

      // Reset mid-stream: start, load identity, push 12 pixels, then reset.
      @(negedge clk) start_i = 1'b1;
      @(negedge clk) start_i = 1'b0;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk); k_valid_i = 1'b1; k_data_i = (i == 4) ? 8'd64 : 8'd0;
      end
      for (int i = 0; i < 12; i++) begin
         @(negedge clk); k_valid_i = 1'b0; out_ready_i = 1'b0;
         pix_valid_i = 1'b1; pix_data_i = 8'(i + 1);
      end
      @(negedge clk) pix_valid_i = 1'b0;
      #1 chk("pre-reset result pending", 32'({out_valid_o, out_data_o}), {20'd0, 1'b1, 11'd6});
      #2 rst_n = 1'b0;
      #1 chk("async reset outputs", 32'({k_ready_o, pix_ready_o, out_valid_o, out_data_o,
                                          out_last_o, busy_o, done_o}), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      run_frame(vecs[0], 10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
